// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, PC/IR/MAR/MDR, 512x32 memory, 64-bit-result ALU.
// All registers load on the rising clock edge; clear is asynchronous and active-low.

module reg32 (
   input  logic        clock,
   input  logic        clear,
   input  logic        ld,
   input  logic [31:0] d,
   output logic [31:0] BusMuxIn
);
   always_ff @(posedge clock or negedge clear) begin
      if (!clear)  BusMuxIn <= '0;
      else if (ld) BusMuxIn <= d;
   end
endmodule

module datapath (
   input  logic        clock,
   input  logic        clear,
   input  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
   input  logic        InPortout, Cout, Rout, BAout,
   input  logic        PCin, IRin, MARin, MDRin, Yin, HIin, LOin,
   input  logic        Zhighin, Zlowin, InPortin, OutPortin, CONin, Rin,
   input  logic        Gra, Grb, Grc,
   input  logic        IncPC, Read, Write, JAL_flag,
   input  logic        Cin,
   input  logic [31:0] InPort_input,
   output logic [31:0] OutPort_out
);
   logic [31:0] bus, pc_val, hi_val, pc_d;
   logic [31:0] ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
   logic [31:0] lo_q, lo_d, inport_q, inport_d, outport_q, outport_d;
   logic [63:0] z_q, z_d, alu_z;
   logic        con_q, con_d;
   logic [31:0] r_q [16];
   logic [31:0] r_d [16];
   logic [31:0] mem [512];
   logic [3:0]  idx, widx;
   logic [31:0] c_sext, alu_lo, quo, rem;
   logic [63:0] prod;
   logic [4:0]  sh;
   logic        unused_ok;

   assign unused_ok = ^{Cin, mar_q[31:9]};

   reg32 PC (.clock(clock), .clear(clear), .ld(PCin), .d(pc_d), .BusMuxIn(pc_val));
   reg32 HI (.clock(clock), .clear(clear), .ld(HIin), .d(bus),  .BusMuxIn(hi_val));

   assign idx    = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) | ({4{Grc}} & ir_q[18:15]);
   assign widx   = JAL_flag ? 4'd15 : idx;
   assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};
   assign OutPort_out = outport_q;

   always_comb begin
      bus = '0;
      if      (PCout)     bus = pc_val;
      else if (MDRout)    bus = mdr_q;
      else if (Zlowout)   bus = z_q[31:0];
      else if (Zhighout)  bus = z_q[63:32];
      else if (HIout)     bus = hi_val;
      else if (LOout)     bus = lo_q;
      else if (InPortout) bus = inport_q;
      else if (Cout)      bus = c_sext;
      else if (Rout)      bus = r_q[idx];
      else if (BAout)     bus = (idx == 4'd0) ? 32'd0 : r_q[idx];
   end

   // ALU: A is Y, B is the bus; shifts and rotates move A by B[4:0].
   always_comb begin
      sh     = bus[4:0];
      prod   = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
      quo    = '0;
      rem    = '0;
      if (bus != 32'd0) begin
         quo = $signed(y_q) / $signed(bus);
         rem = $signed(y_q) % $signed(bus);
      end
      alu_lo = y_q + bus;
      case (ir_q[31:27])
         5'b00100: alu_lo = y_q - bus;
         5'b00101: alu_lo = y_q >> sh;
         5'b00110: alu_lo = 32'($signed(y_q) >>> sh);
         5'b00111: alu_lo = y_q << sh;
         5'b01000: alu_lo = (y_q >> sh) | (y_q << (6'd32 - {1'b0, sh}));
         5'b01001: alu_lo = (y_q << sh) | (y_q >> (6'd32 - {1'b0, sh}));
         5'b01010, 5'b01101: alu_lo = y_q & bus;
         5'b01011, 5'b01110: alu_lo = y_q | bus;
         5'b10001: alu_lo = -bus;
         5'b10010: alu_lo = ~bus;
         default:  alu_lo = y_q + bus;
      endcase
      case (ir_q[31:27])
         5'b01111: alu_z = prod;
         5'b10000: alu_z = {rem, quo};
         default:  alu_z = {32'd0, alu_lo};
      endcase
   end

   always_comb begin
      pc_d      = IncPC ? pc_val + 32'd1 : bus;
      ir_d      = IRin  ? bus : ir_q;
      mar_d     = MARin ? bus : mar_q;
      mdr_d     = mdr_q;
      if (MDRin) mdr_d = Read ? mem[mar_q[8:0]] : bus;
      y_d       = Yin   ? bus : y_q;
      lo_d      = LOin  ? bus : lo_q;
      inport_d  = InPortin  ? InPort_input : inport_q;
      outport_d = OutPortin ? bus : outport_q;
      z_d       = {Zhighin ? alu_z[63:32] : z_q[63:32], Zlowin ? alu_z[31:0] : z_q[31:0]};
      con_d     = con_q;
      if (CONin) begin
         case (ir_q[20:19])
            2'b00:   con_d = (bus == 32'd0);
            2'b01:   con_d = (bus != 32'd0);
            2'b10:   con_d = ~bus[31];
            default: con_d = bus[31];
         endcase
      end
      r_d = r_q;
      if (Rin) r_d[widx] = bus;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         ir_q      <= '0;
         mar_q     <= '0;
         mdr_q     <= '0;
         y_q       <= '0;
         lo_q      <= '0;
         inport_q  <= '0;
         outport_q <= '0;
         z_q       <= '0;
         con_q     <= 1'b0;
         for (int i = 0; i < 16; i++) r_q[i] <= '0;
      end else begin
         ir_q      <= ir_d;
         mar_q     <= mar_d;
         mdr_q     <= mdr_d;
         y_q       <= y_d;
         lo_q      <= lo_d;
         inport_q  <= inport_d;
         outport_q <= outport_d;
         z_q       <= z_d;
         con_q     <= con_d;
         for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      end
   end

   // Memory survives clear; writes are merely suppressed while clear is low.
   always_ff @(posedge clock) begin
      if (Write && clear) mem[mar_q[8:0]] <= mdr_q;
   end
endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
   logic        clock, clear;
   logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout;
   logic        PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin, InPortin, OutPortin, CONin, Rin;
   logic        Gra, Grb, Grc, IncPC, Read, Write, JAL_flag, Cin;
   logic [31:0] InPort_input, OutPort_out;
   logic [31:0] ir_v;
   int          n_cmp = 0;
   int          n_err = 0;

   datapath dut (
      .clock(clock), .clear(clear),
      .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
      .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
      .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
      .Zhighin(Zhighin), .Zlowin(Zlowin), .InPortin(InPortin), .OutPortin(OutPortin),
      .CONin(CONin), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read),
      .Write(Write), .JAL_flag(JAL_flag), .Cin(Cin), .InPort_input(InPort_input),
      .OutPort_out(OutPort_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout} = '0;
      {PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin, InPortin, OutPortin, CONin, Rin} = '0;
      {Gra, Grb, Grc, IncPC, Read, Write, JAL_flag, Cin} = '0;
   endtask

   // Load the InPort register with a value, leaving it ready to drive the bus.
   task automatic put(input logic [31:0] v);
      idle(); InPort_input = v; InPortin = 1'b1; tick(); idle();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      clear = 1'b0;
      InPort_input = '0;
      idle();
      #7;
      chk("reset_outport", OutPort_out, 32'd0);
      chk("reset_pc", dut.PC.BusMuxIn, 32'd0);
      #5 clear = 1'b1;
      #1;

      // Store instruction word at mem[15], set PC = 15, HI = 30
      put(32'd15);          InPortout = 1; MARin = 1; tick();
      put(32'hC980_0000);   InPortout = 1; MDRin = 1; tick();
      idle(); Write = 1; tick();
      put(32'd15);          InPortout = 1; PCin = 1; tick();
      chk("pc_preload", dut.PC.BusMuxIn, 32'd15);
      put(32'd30);          InPortout = 1; HIin = 1; tick();

      // Fetch
      idle(); PCout = 1; MARin = 1; IncPC = 1; PCin = 1; tick();
      chk("t0_mar", dut.mar_q, 32'd15);
      chk("t0_pc", dut.PC.BusMuxIn, 32'd16);
      idle(); Read = 1; MDRin = 1; tick();
      chk("t1_mdr", dut.mdr_q, 32'hC980_0000);
      idle(); MDRout = 1; IRin = 1; tick();
      chk("t2_ir", dut.ir_q, 32'hC980_0000);
      idle(); Gra = 1; Rin = 1; HIout = 1; tick();
      chk("mfhi_r3", dut.r_q[3], 32'd30);
      chk("mfhi_hi", dut.HI.BusMuxIn, 32'd30);

      // add: R6 = R1 + R2
      ir_v = {5'b00011, 4'd6, 4'd1, 4'd2, 15'd0};
      put(ir_v);    InPortout = 1; IRin = 1; tick();
      put(32'd7);   InPortout = 1; Grb = 1; Rin = 1; tick();
      put(32'd5);   InPortout = 1; Grc = 1; Rin = 1; tick();
      idle(); Grb = 1; Rout = 1; Yin = 1; tick();
      idle(); Grc = 1; Rout = 1; Zlowin = 1; Zhighin = 1; tick();
      idle(); Zlowout = 1; Gra = 1; Rin = 1; tick();
      chk("add_r6", dut.r_q[6], 32'd12);
      idle(); Zhighout = 1; OutPortin = 1; tick();
      chk("add_zhigh", OutPort_out, 32'd0);

      // mul -1 * 3
      ir_v = {5'b01111, 27'd0};
      put(ir_v);           InPortout = 1; IRin = 1; tick();
      put(32'hFFFF_FFFF);  InPortout = 1; Yin = 1; tick();
      put(32'd3);          InPortout = 1; Zlowin = 1; Zhighin = 1; tick();
      idle(); Zhighout = 1; OutPortin = 1; tick();
      chk("mul_zhigh", OutPort_out, 32'hFFFF_FFFF);
      idle(); Zlowout = 1; OutPortin = 1; tick();
      chk("mul_zlow", OutPort_out, 32'hFFFF_FFFD);

      // div 17 / 5, then divide by zero
      ir_v = {5'b10000, 27'd0};
      put(ir_v);   InPortout = 1; IRin = 1; tick();
      put(32'd17); InPortout = 1; Yin = 1; tick();
      put(32'd5);  InPortout = 1; Zlowin = 1; Zhighin = 1; tick();
      idle(); Zlowout = 1; LOin = 1; tick();
      idle(); Zhighout = 1; HIin = 1; tick();
      chk("div_lo", dut.lo_q, 32'd3);
      chk("div_hi", dut.HI.BusMuxIn, 32'd2);
      put(32'd0);  InPortout = 1; Zlowin = 1; Zhighin = 1; tick();
      idle(); Zlowout = 1; OutPortin = 1; tick();
      chk("div0_zlow", OutPort_out, 32'd0);

      // ror 1 by 1
      ir_v = {5'b01000, 27'd0};
      put(ir_v);  InPortout = 1; IRin = 1; tick();
      put(32'd1); InPortout = 1; Yin = 1; tick();
      idle(); InPortout = 1; Zlowin = 1; tick();
      idle(); Zlowout = 1; OutPortin = 1; tick();
      chk("ror", OutPort_out, 32'h8000_0000);

      // BAout with index 0, Cout sign extension, CON
      ir_v = {5'b00000, 4'd0, 4'd0, 19'h40001};
      put(ir_v);     InPortout = 1; IRin = 1; tick();
      put(32'h55);   InPortout = 1; Gra = 1; Rin = 1; tick();
      idle(); Gra = 1; Rout = 1; OutPortin = 1; tick();
      chk("rout_r0", OutPort_out, 32'h55);
      idle(); Gra = 1; BAout = 1; OutPortin = 1; tick();
      chk("baout_r0", OutPort_out, 32'd0);
      idle(); Cout = 1; OutPortin = 1; tick();
      chk("cout_sext", OutPort_out, 32'hFFFC_0001);
      put(32'd0); InPortout = 1; CONin = 1; tick();
      chk("con_zero", {31'd0, dut.con_q}, 32'd1);
      put(32'd4); InPortout = 1; CONin = 1; tick();
      chk("con_nonzero", {31'd0, dut.con_q}, 32'd0);

      // jal forces R15
      put(32'hABC); InPortout = 1; Gra = 1; Rin = 1; JAL_flag = 1; tick();
      chk("jal_r15", dut.r_q[15], 32'hABC);

      // Mid-cycle reset, no loads while low, memory retained
      idle();
      #2 clear = 1'b0;
      #1;
      chk("rst_pc", dut.PC.BusMuxIn, 32'd0);
      chk("rst_r3", dut.r_q[3], 32'd0);
      chk("rst_outport", OutPort_out, 32'd0);
      PCin = 1; IncPC = 1; tick();
      chk("rst_hold_pc", dut.PC.BusMuxIn, 32'd0);
      clear = 1'b1;
      tick();
      chk("rst_resume_pc", dut.PC.BusMuxIn, 32'd1);
      put(32'd15); InPortout = 1; MARin = 1; tick();
      idle(); Read = 1; MDRin = 1; tick();
      chk("mem_retained", dut.mdr_q, 32'hC980_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
